// File: rtl/inst_fetch_sequencer.sv
// Instruction fetch sequencer: streams a block of words from imem port B
// into a small first-word-fall-through prefetch FIFO that feeds the decoder
// over a valid/ready handshake. A credit check on FIFO occupancy plus the
// single in-flight read keeps the FIFO from ever overflowing.
module inst_fetch_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int COUNT_WIDTH = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_inst,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic                   imem_read_req,
  output logic [ADDR_WIDTH-1:0]  imem_read_addr,
  input  logic [DATA_WIDTH-1:0]  imem_read_data,
  output logic                   inst_valid,
  output logic [DATA_WIDTH-1:0]  inst_data,
  input  logic                   inst_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COUNT_WIDTH-1:0] issue_cnt_q;
  logic [COUNT_WIDTH-1:0] retire_cnt_q;
  logic                   inflight_q;

  logic [DATA_WIDTH-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       fifo_cnt_q;

  logic [CNT_W:0]         occupancy;
  logic                   credit_ok;
  logic                   push;
  logic                   pop;

  // Occupancy counts the word already requested but not yet returned, so a
  // new request is only made when a slot is guaranteed for its data.
  assign occupancy     = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok     = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign imem_read_req = (state_q == S_FETCH) && (issue_cnt_q != '0) && credit_ok;
  assign imem_read_addr = addr_q;

  // A return is dropped if flush hits in its request cycle (inflight_q is
  // cleared) or in its return cycle (push gated here).
  assign push       = inflight_q && !flush;
  assign inst_valid = (fifo_cnt_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = fifo_mem_q[rd_ptr_q];

  assign busy = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  // Control FSM with address and issue/retire counters; flush overrides all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issue_cnt_q  <= '0;
      retire_cnt_q <= '0;
      inflight_q   <= 1'b0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issue_cnt_q  <= '0;
      retire_cnt_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= imem_read_req;
      if (pop) begin
        retire_cnt_q <= retire_cnt_q - 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q       <= base_addr;
            issue_cnt_q  <= num_inst;
            retire_cnt_q <= num_inst;
            state_q      <= (num_inst != '0) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: begin
          if (imem_read_req) begin
            addr_q      <= addr_q + 1'b1;
            issue_cnt_q <= issue_cnt_q - 1'b1;
            if (issue_cnt_q == COUNT_WIDTH'(1)) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && (retire_cnt_q == COUNT_WIDTH'(1))) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
    end
  end

  // FIFO storage: one register per entry, written when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          fifo_mem_q[gi] <= imem_read_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Directed testbench for inst_fetch_sequencer with a behavioural imem model.
module tb_inst_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic [15:0] num_inst;
  logic        flush;
  logic        busy;
  logic        done;
  logic        imem_read_req;
  logic [10:0] imem_read_addr;
  logic [31:0] imem_read_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        inst_ready;

  int errors = 0;
  int checks = 0;
  int req_cnt = 0;

  inst_fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_inst       (num_inst),
    .flush          (flush),
    .busy           (busy),
    .done           (done),
    .imem_read_req  (imem_read_req),
    .imem_read_addr (imem_read_addr),
    .imem_read_data (imem_read_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return {21'h0ABCD, a};
  endfunction

  // imem port B: one-cycle read latency
  always @(posedge clk) begin
    if (imem_read_req) imem_read_data <= mem_word(imem_read_addr);
  end

  // running count of issued reads
  always @(posedge clk) begin
    if (imem_read_req) req_cnt <= req_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_prog(input string tag, input logic [10:0] b, input int n, input int ncyc);
    int nreq;
    int nw;
    int nd;
    logic [10:0] ea;
    nreq = 0; nw = 0; nd = 0;
    base_addr = b; num_inst = 16'(n); inst_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (imem_read_req) begin
        ea = b + 11'(nreq);
        chk({tag, "_addr"}, 32'(imem_read_addr), 32'(ea));
        nreq++;
      end
      if (inst_valid && inst_ready) begin
        ea = b + 11'(nw);
        chk({tag, "_data"}, inst_data, mem_word(ea));
        nw++;
      end
      if (done) nd++;
      tick();
    end
    chk({tag, "_nreq"}, 32'(nreq), 32'(n));
    chk({tag, "_nwords"}, 32'(nw), 32'(n));
    chk({tag, "_ndone"}, 32'(nd), 32'd1);
    $display("%s: base=%h num=%0d reqs=%0d words=%0d dones=%0d", tag, b, n, nreq, nw, nd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int nw;
    int nd;
    int nacc;

    reset = 1'b1; start = 1'b0; base_addr = '0; num_inst = '0;
    flush = 1'b0; inst_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(imem_read_req), 32'd0);
    chk("rst_addr", 32'(imem_read_addr), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    reset = 1'b0;
    tick();
    $display("reset: busy=%0d valid=%0d", busy, inst_valid);

    // 1: basic stream of 5 words, exact cycle timing
    start = 1'b1; base_addr = 11'h010; num_inst = 16'd5; inst_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      chk("t1_req", 32'(imem_read_req), 32'(i <= 5));
      if (i <= 5) chk("t1_addr", 32'(imem_read_addr), 32'(11'h010 + 11'(i - 1)));
      chk("t1_valid", 32'(inst_valid), 32'(i >= 3));
      if (i >= 3) chk("t1_data", inst_data, mem_word(11'h010 + 11'(i - 3)));
      chk("t1_done", 32'(done), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("t1_done_pulse", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_valid_end", 32'(inst_valid), 32'd0);
    tick();
    chk("t1_done_clear", 32'(done), 32'd0);
    $display("t1 basic: done pulse observed, valid=%0d", inst_valid);

    // 2: backpressure, 12 words with decoder stalled for 20 cycles
    r0 = req_cnt;
    inst_ready = 1'b0; start = 1'b1; base_addr = 11'h100; num_inst = 16'd12;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("t2_stall_reqs", 32'(req_cnt - r0), 32'd4);
    chk("t2_stall_valid", 32'(inst_valid), 32'd1);
    chk("t2_stall_head", inst_data, mem_word(11'h100));
    inst_ready = 1'b1;
    nw = 0; nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (inst_valid) begin
        chk("t2_data", inst_data, mem_word(11'h100 + 11'(nw)));
        nw++;
      end
      if (done) nd++;
      tick();
    end
    chk("t2_nwords", 32'(nw), 32'd12);
    chk("t2_ndone", 32'(nd), 32'd1);
    chk("t2_total_reqs", 32'(req_cnt - r0), 32'd12);
    $display("t2 backpressure: words=%0d dones=%0d reqs=%0d", nw, nd, req_cnt - r0);

    // 3: address wrap at the top of the 11-bit space
    run_prog("t3_wrap", 11'h7FE, 4, 12);

    // 4: zero-length program
    r0 = req_cnt;
    start = 1'b1; base_addr = 11'h123; num_inst = 16'd0;
    tick();
    start = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_req", 32'(imem_read_req), 32'd0);
    tick();
    chk("t4_done_clear", 32'(done), 32'd0);
    chk("t4_busy2", 32'(busy), 32'd0);
    tick();
    chk("t4_no_reqs", 32'(req_cnt - r0), 32'd0);
    $display("t4 zero count: reqs=%0d", req_cnt - r0);

    // 5: flush on the 7th accept with a read in flight
    start = 1'b1; base_addr = 11'h300; num_inst = 16'd100; inst_ready = 1'b1;
    tick();
    start = 1'b0;
    nacc = 0;
    for (int c = 0; c < 20 && nacc < 7; c++) begin
      if (inst_valid && inst_ready) begin
        chk("t5_data", inst_data, mem_word(11'h300 + 11'(nacc)));
        nacc++;
      end
      if (nacc < 7) tick();
    end
    chk("t5_reach7", 32'(nacc), 32'd7);
    chk("t5_inflight", 32'(imem_read_req), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_valid", 32'(inst_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_req", 32'(imem_read_req), 32'd0);
    nd = 0; nw = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) nd++;
      if (inst_valid) nw++;
      tick();
    end
    chk("t5_no_done", 32'(nd), 32'd0);
    chk("t5_no_words", 32'(nw), 32'd0);
    $display("t5 flush: accepts=%0d words_after=%0d dones=%0d", nacc, nw, nd);
    run_prog("t5_restart", 11'h200, 3, 10);

    // 6: start while busy is ignored, then reset in DRAIN
    r0 = req_cnt;
    start = 1'b1; base_addr = 11'h050; num_inst = 16'd6; inst_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t6_req", 32'(imem_read_req), 32'd1);
      chk("t6_addr", 32'(imem_read_addr), 32'(11'h050 + 11'(i)));
      if (i == 1) begin
        start = 1'b1; base_addr = 11'h7AA; num_inst = 16'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("t6_drain_req", 32'(imem_read_req), 32'd0);
    chk("t6_drain_busy", 32'(busy), 32'd1);
    chk("t6_nreqs", 32'(req_cnt - r0), 32'd6);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_req", 32'(imem_read_req), 32'd0);
    chk("t6_rst_addr", 32'(imem_read_addr), 32'd0);
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6_post_done", 32'(done), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd0);
    $display("t6 start-while-busy/reset: reqs=%0d busy=%0d", req_cnt - r0, busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
